// File: rtl/pot_scan_sequencer.sv
// Round-robin scanner of the six equalizer slide pots through the A2D SPI master.
// Optional build macro POT_AVG_EN: each register update becomes a rounded 2-tap running average.
module pot_scan_sequencer #(
  parameter int          SCAN_GAP = 256,
  parameter int          TIMEOUT  = 4096,
  parameter logic [2:0]  CH_LP    = 3'd1,
  parameter logic [2:0]  CH_B1    = 3'd0,
  parameter logic [2:0]  CH_B2    = 3'd4,
  parameter logic [2:0]  CH_B3    = 3'd2,
  parameter logic [2:0]  CH_HP    = 3'd3,
  parameter logic [2:0]  CH_VOL   = 3'd7
) (
  input  logic        clk,
  input  logic        RST_n,
  output logic        a2d_strt,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME,
  output logic        sweep_done,
  output logic        timeout_err
);

  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_GAP, S_START, S_WAIT} state_t;
  typedef enum logic [2:0] {
    SLOT_LP, SLOT_B1, SLOT_B2, SLOT_B3, SLOT_HP, SLOT_VOL
  } slot_t;

  state_t            state;
  slot_t             slot;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [11:0]       new_val;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    chnnl = CH_LP;
    case (slot)
      SLOT_LP:  chnnl = CH_LP;
      SLOT_B1:  chnnl = CH_B1;
      SLOT_B2:  chnnl = CH_B2;
      SLOT_B3:  chnnl = CH_B3;
      SLOT_HP:  chnnl = CH_HP;
      SLOT_VOL: chnnl = CH_VOL;
      default:  chnnl = CH_LP;
    endcase
  end

`ifdef POT_AVG_EN
  logic [11:0] old_val;

  always_comb begin
    old_val = POT_LP;
    case (slot)
      SLOT_LP:  old_val = POT_LP;
      SLOT_B1:  old_val = POT_B1;
      SLOT_B2:  old_val = POT_B2;
      SLOT_B3:  old_val = POT_B3;
      SLOT_HP:  old_val = POT_HP;
      SLOT_VOL: old_val = VOLUME;
      default:  old_val = POT_LP;
    endcase
  end

  // 13-bit sum keeps the carry; the +1 rounds the halving up.
  assign new_val = 12'(({1'b0, old_val} + {1'b0, res} + 13'd1) >> 1);
`else
  assign new_val = res;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state       <= S_GAP;
      slot        <= SLOT_LP;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      a2d_strt    <= 1'b0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
      POT_LP      <= 12'h800;
      POT_B1      <= 12'h800;
      POT_B2      <= 12'h800;
      POT_B3      <= 12'h800;
      POT_HP      <= 12'h800;
      VOLUME      <= 12'h000;
    end else begin
      a2d_strt   <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_START;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_START: begin
          a2d_strt <= 1'b1;
          tmo_cnt  <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is tested first so it wins over a coincident timeout.
          if (cnv_cmplt) begin
            case (slot)
              SLOT_LP:  POT_LP <= new_val;
              SLOT_B1:  POT_B1 <= new_val;
              SLOT_B2:  POT_B2 <= new_val;
              SLOT_B3:  POT_B3 <= new_val;
              SLOT_HP:  POT_HP <= new_val;
              SLOT_VOL: VOLUME <= new_val;
              default:  ;
            endcase
            if (slot >= SLOT_VOL) begin
              slot       <= SLOT_LP;
              sweep_done <= 1'b1;
            end else begin
              slot <= slot_t'(slot + 3'd1);
            end
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_GAP;
      endcase
    end
  end

endmodule

// File: doc/pot_scan_sequencer.md
Name: pot_scan_sequencer

Overview:
Sequences the A2D SPI master, round-robin, through the six equalizer slide pots: LP, B1, B2, B3, HP and VOLUME. Latches each 12-bit result into a dedicated gain register that drives the band-filter scalers and the volume multiplier. Paces conversions with an inter-conversion gap timer and recovers from a hung conversion with a timeout and retry. Sits between the A2D SPI interface (ADC128S side) and the equalizer datapath.

Parameters:
SCAN_GAP, 256, idle clk cycles between completion of one conversion and start of the next (min 1)
TIMEOUT, 4096, clk cycles to wait for cnv_cmplt before aborting and retrying the same channel
CH_LP/CH_B1/CH_B2/CH_B3/CH_HP/CH_VOL, 1/0/4/2/3/7, A2D channel number for each pot

Ports:
clk  in  1  system clock
RST_n  in  1  asynchronous active-low reset
a2d_strt  out  1  one-cycle pulse requesting a conversion on chnnl
chnnl  out  3  A2D channel for the current conversion; held stable from strt until cmplt/timeout
cnv_cmplt  in  1  one-cycle pulse from the SPI master; res valid this cycle
res  in  12  conversion result
POT_LP, POT_B1, POT_B2, POT_B3, POT_HP  out  12 each  band gain registers (0x800 = unity)
VOLUME  out  12  volume register
sweep_done  out  1  one-cycle pulse after VOLUME is written (a full sweep is complete)
timeout_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset values: all POT_* = 12'h800; VOLUME = 12'h000; a2d_strt = 0; sweep_done = 0; timeout_err = 0; chnnl = CH_LP; slot index = 0; state = GAP; gap counter = 0.
- Slot order: LP, B1, B2, B3, HP, VOL, then wrap to LP. chnnl is a combinational decode of the slot index.
- States:
  - GAP: count up to SCAN_GAP-1, then -> START.
  - START: assert a2d_strt for exactly 1 cycle; clear the timeout counter; -> WAIT.
  - WAIT: on cnv_cmplt, write res into the slot's register on the same edge, advance the slot, clear the gap counter, -> GAP. If VOL was the slot written, pulse sweep_done on that same edge.
  - WAIT timeout: if the timeout counter reaches TIMEOUT-1 without cnv_cmplt, set timeout_err, keep the slot unchanged, -> GAP (the same channel is retried).
- Stray cnv_cmplt outside WAIT is ignored; no register write and no state change.
- cnv_cmplt in the same cycle as the timeout terminal count: completion wins; the result is written and timeout_err is not set.
- Latency: res is visible on POT_* / VOLUME one clk after the cnv_cmplt edge. First a2d_strt occurs SCAN_GAP+1 cycles after reset deasserts.
- A full sweep takes 6 × (SCAN_GAP + 1 + conversion time) cycles.
- Reset asserted mid-conversion: everything returns to reset values at once. Any late cnv_cmplt arriving after reset release lands in GAP and is ignored.
- Counters are sized to hold SCAN_GAP-1 and TIMEOUT-1 with no wrap. Slot index is 3 bits and wraps 5 -> 0.

Optional Feature:
POT_AVG_EN
- Defined: each register update becomes new = (old + res + 1) >> 1. Use a 13-bit sum and round half up. This gives a 2-tap running average that suppresses pot jitter. Reset values are unchanged.
- Undefined: the register is loaded with res directly.
- sweep_done timing and all other behaviour are identical in both builds.

Test Plan:
- Reset release, SCAN_GAP=4, responder returns res = {9'h0, chnnl} << 8 four cycles after strt -> chnnl sequence 1,0,4,2,3,7,1. POT_LP = 0x100, POT_B1 = 0x000, POT_B2 = 0x400, POT_B3 = 0x200, POT_HP = 0x300, VOLUME = 0x700. One sweep_done per sweep, coinciding with the VOLUME write.
- Gap timing: measure cycles from a cnv_cmplt to the next a2d_strt -> exactly SCAN_GAP+1 = 5; a2d_strt is high for exactly 1 cycle.
- Responder drops the B2 conversion, TIMEOUT=16 -> timeout_err sets 16 cycles after strt. The next strt is again chnnl=4. POT_B2 updates on the retry and timeout_err stays 1.
- Stray cnv_cmplt with res=0xFFF pulsed during GAP -> no POT_* / VOLUME change and the slot does not advance. cnv_cmplt coincident with the timeout terminal count -> value written, timeout_err stays 0.
- RST_n pulsed low while in WAIT on HP -> all outputs return to reset values asynchronously (POT_* = 0x800, VOLUME = 0). The post-reset first strt uses chnnl=1.
- POT_AVG_EN defined, POT_LP = 0x800, res = 0xFFF -> POT_LP = 0xC00. Next res = 0xFFF -> 0xE00. With the macro undefined -> 0xFFF directly.
